// File: rtl/arch_defs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arch_defs_pkg
//  Description : Shared opcode, state and control-word definitions for the
//                8-bit bus computer and its microcoded sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package arch_defs_pkg;

    localparam int OPCODE_WIDTH = 4;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_LDB = 4'h2,
        OP_ADD = 4'h3,
        OP_SUB = 4'h4,
        OP_STA = 4'h5,
        OP_LDI = 4'h6,
        OP_JMP = 4'h7,
        OP_JC  = 4'h8,
        OP_JZ  = 4'h9,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH_PC  = 3'd0,
        S_FETCH_RAM = 3'd1,
        S_DECODE    = 3'd2,
        S_EX0       = 3'd3,
        S_EX1       = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    // First member is the MSB of the packed word.
    typedef struct packed {
        logic pc_oe;
        logic pc_inc;
        logic pc_load;
        logic mar_load;
        logic ram_oe;
        logic ram_we;
        logic ir_oe;
        logic ir_load;
        logic a_oe;
        logic a_load;
        logic b_load;
        logic alu_oe;
        logic alu_sub;
        logic flags_load;
        logic o_load;
    } control_word_t;

    // Opcodes that own at least one execute step; 0xA-0xD fall through as NOP.
    function automatic logic is_exec_op(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_LDB) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_STA) || (op == OP_LDI) ||
               (op == OP_JMP) || (op == OP_JC)  || (op == OP_JZ)  ||
               (op == OP_OUT);
    endfunction

    // Opcodes needing a memory access after the address phase.
    function automatic logic is_two_step(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_LDB) || (op == OP_STA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/microcode_rom.sv
`default_nettype none
// ============================================================================
//  Module      : microcode_rom
//  Description : Purely combinational decode of (state, opcode, flags) into
//                the datapath control word. New opcodes are added here only.
//  Revision    : 1.0 - initial release
// ============================================================================
module microcode_rom
    import arch_defs_pkg::*;
(
    input  state_t                  state_i,
    input  logic [OPCODE_WIDTH-1:0] opcode_i,
    input  logic                    flag_zero_i,
    input  logic                    flag_carry_i,
    output control_word_t           control_word_o
);

    // Control word lookup; every unlisted combination drives nothing.
    always_comb begin
        control_word_o = '0;
        case (state_i)
            S_FETCH_PC: begin
                control_word_o.pc_oe    = 1'b1;
                control_word_o.mar_load = 1'b1;
            end
            S_FETCH_RAM: begin
                control_word_o.ram_oe  = 1'b1;
                control_word_o.ir_load = 1'b1;
                control_word_o.pc_inc  = 1'b1;
            end
            S_EX0: begin
                case (opcode_i)
                    OP_LDA, OP_LDB, OP_STA: begin
                        control_word_o.ir_oe    = 1'b1;
                        control_word_o.mar_load = 1'b1;
                    end
                    OP_ADD: begin
                        control_word_o.alu_oe     = 1'b1;
                        control_word_o.a_load     = 1'b1;
                        control_word_o.flags_load = 1'b1;
                    end
                    OP_SUB: begin
                        control_word_o.alu_oe     = 1'b1;
                        control_word_o.alu_sub    = 1'b1;
                        control_word_o.a_load     = 1'b1;
                        control_word_o.flags_load = 1'b1;
                    end
                    OP_LDI: begin
                        control_word_o.ir_oe  = 1'b1;
                        control_word_o.a_load = 1'b1;
                    end
                    OP_JMP: begin
                        control_word_o.ir_oe   = 1'b1;
                        control_word_o.pc_load = 1'b1;
                    end
                    OP_JC: begin
                        control_word_o.ir_oe   = flag_carry_i;
                        control_word_o.pc_load = flag_carry_i;
                    end
                    OP_JZ: begin
                        control_word_o.ir_oe   = flag_zero_i;
                        control_word_o.pc_load = flag_zero_i;
                    end
                    OP_OUT: begin
                        control_word_o.a_oe   = 1'b1;
                        control_word_o.o_load = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EX1: begin
                case (opcode_i)
                    OP_LDA: begin
                        control_word_o.ram_oe = 1'b1;
                        control_word_o.a_load = 1'b1;
                    end
                    OP_LDB: begin
                        control_word_o.ram_oe = 1'b1;
                        control_word_o.b_load = 1'b1;
                    end
                    OP_STA: begin
                        control_word_o.a_oe   = 1'b1;
                        control_word_o.ram_we = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : control_sequencer
//  Description : Fetch/decode/execute sequencer. Holds the state register and
//                next-state logic; the control word comes from microcode_rom.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
    import arch_defs_pkg::*;
#(
    parameter int     OPCODE_WIDTH = 4,
    parameter state_t RESET_STATE  = S_FETCH_PC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    flag_zero,
    input  logic                    flag_carry,
    output control_word_t           control_word,
    output logic                    halt,
    output state_t                  state
);

    state_t        state_q;
    state_t        state_d;
    control_word_t rom_word;

    // State register; reset aborts any instruction in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing; HALT only leaves through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH_PC:  state_d = S_FETCH_RAM;
            S_FETCH_RAM: state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_HLT) begin
                    state_d = S_HALT;
                end else if (is_exec_op(opcode)) begin
                    state_d = S_EX0;
                end else begin
                    state_d = S_FETCH_PC;
                end
            end
            S_EX0:   state_d = is_two_step(opcode) ? S_EX1 : S_FETCH_PC;
            S_EX1:   state_d = S_FETCH_PC;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH_PC;
        endcase
    end

    microcode_rom u_rom (
        .state_i        (state_q),
        .opcode_i       (opcode),
        .flag_zero_i    (flag_zero),
        .flag_carry_i   (flag_carry),
        .control_word_o (rom_word)
    );

    // Reset masks the word so no datapath register loads while it is held.
    always_comb begin
        control_word = reset ? '0 : rom_word;
        halt         = ~reset & (state_q == S_HALT);
        state        = state_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_sequencer
//  Description : Directed bench for control_sequencer with a small behavioural
//                datapath for the full-system program run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;
    import arch_defs_pkg::*;

    localparam logic [14:0] c_PC_OE      = 15'h4000;
    localparam logic [14:0] c_PC_INC     = 15'h2000;
    localparam logic [14:0] c_PC_LOAD    = 15'h1000;
    localparam logic [14:0] c_MAR_LOAD   = 15'h0800;
    localparam logic [14:0] c_RAM_OE     = 15'h0400;
    localparam logic [14:0] c_RAM_WE     = 15'h0200;
    localparam logic [14:0] c_IR_OE      = 15'h0100;
    localparam logic [14:0] c_IR_LOAD    = 15'h0080;
    localparam logic [14:0] c_A_OE       = 15'h0040;
    localparam logic [14:0] c_A_LOAD     = 15'h0020;
    localparam logic [14:0] c_B_LOAD     = 15'h0010;
    localparam logic [14:0] c_ALU_OE     = 15'h0008;
    localparam logic [14:0] c_ALU_SUB    = 15'h0004;
    localparam logic [14:0] c_FLAGS_LOAD = 15'h0002;
    localparam logic [14:0] c_O_LOAD     = 15'h0001;
    localparam logic [14:0] c_FETCH_PC   = c_PC_OE | c_MAR_LOAD;
    localparam logic [14:0] c_FETCH_RAM  = c_RAM_OE | c_IR_LOAD | c_PC_INC;

    typedef struct packed {
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic [14:0] ex0;
        logic [14:0] ex1;
        logic [2:0]  len;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    op_tb = 4'h0;
    logic          fz_tb = 1'b0;
    logic          fc_tb = 1'b0;
    logic          use_sys = 1'b0;
    logic [3:0]    opcode_drv;
    logic          fz_drv;
    logic          fc_drv;
    control_word_t cw;
    logic [14:0]   cw_bits;
    logic          halt;
    state_t        st;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural datapath driven by the control word
    logic [3:0] m_pc, m_mar;
    logic [7:0] m_ir, m_a, m_b, m_out, m_bus;
    logic       m_z, m_c;
    logic [8:0] m_alu;
    logic [7:0] m_ram [16];

    assign opcode_drv = use_sys ? m_ir[7:4] : op_tb;
    assign fz_drv     = use_sys ? m_z : fz_tb;
    assign fc_drv     = use_sys ? m_c : fc_tb;
    assign cw_bits    = cw;

    always #5 clk = ~clk;

    control_sequencer #(
        .OPCODE_WIDTH (4),
        .RESET_STATE  (S_FETCH_PC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode_drv),
        .flag_zero    (fz_drv),
        .flag_carry   (fc_drv),
        .control_word (cw),
        .halt         (halt),
        .state        (st)
    );

    always_comb begin
        m_alu = cw.alu_sub ? ({1'b0, m_a} - {1'b0, m_b}) : ({1'b0, m_a} + {1'b0, m_b});
        m_bus = 8'h00;
        if (cw.pc_oe)       m_bus = {4'h0, m_pc};
        else if (cw.ram_oe) m_bus = m_ram[m_mar];
        else if (cw.ir_oe)  m_bus = {4'h0, m_ir[3:0]};
        else if (cw.a_oe)   m_bus = m_a;
        else if (cw.alu_oe) m_bus = m_alu[7:0];
    end

    always @(posedge clk) begin
        if (reset) begin
            m_pc <= 4'h0; m_mar <= 4'h0; m_ir <= 8'h00;
            m_a <= 8'h00; m_b <= 8'h00; m_out <= 8'h00;
            m_z <= 1'b0; m_c <= 1'b0;
            for (int i = 0; i < 16; i++) m_ram[i] <= 8'h00;
            m_ram[0]  <= 8'h2E;   // LDB 14
            m_ram[1]  <= 8'h65;   // LDI 5
            m_ram[2]  <= 8'h30;   // ADD
            m_ram[3]  <= 8'hE0;   // OUT
            m_ram[4]  <= 8'hF0;   // HLT
            m_ram[14] <= 8'h11;
        end else begin
            if (cw.mar_load) m_mar <= m_bus[3:0];
            if (cw.pc_load) m_pc <= m_bus[3:0];
            else if (cw.pc_inc) m_pc <= m_pc + 4'h1;
            if (cw.ir_load) m_ir <= m_bus;
            if (cw.a_load) m_a <= m_bus;
            if (cw.b_load) m_b <= m_bus;
            if (cw.o_load) m_out <= m_bus;
            if (cw.ram_we) m_ram[m_mar] <= m_a;
            if (cw.flags_load) begin
                m_c <= m_alu[8];
                m_z <= (m_alu[7:0] == 8'h00);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (st !== S_FETCH_PC || cw_bits !== 15'h0 || halt !== 1'b0)
                $display("FAIL reset_hold cyc=%0d state=%0d cw=%h halt=%b want state=0 cw=0000 halt=0",
                         i, st, cw_bits, halt);
            else n_pass++;
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (st !== S_FETCH_PC || cw_bits !== c_FETCH_PC)
            $display("FAIL reset_first_word state=%0d cw=%h want state=0 cw=%h", st, cw_bits, c_FETCH_PC);
        else n_pass++;
    endtask

    task automatic test_decode_table();
        vec_t   tbl [18];
        state_t exp_st;
        logic [14:0] exp_cw;
        tbl[0]  = '{4'h0, 1'b0, 1'b0, 15'h0, 15'h0, 3'd3};
        tbl[1]  = '{4'h1, 1'b0, 1'b0, c_IR_OE | c_MAR_LOAD, c_RAM_OE | c_A_LOAD, 3'd5};
        tbl[2]  = '{4'h2, 1'b0, 1'b0, c_IR_OE | c_MAR_LOAD, c_RAM_OE | c_B_LOAD, 3'd5};
        tbl[3]  = '{4'h3, 1'b0, 1'b0, c_ALU_OE | c_A_LOAD | c_FLAGS_LOAD, 15'h0, 3'd4};
        tbl[4]  = '{4'h4, 1'b0, 1'b0, c_ALU_OE | c_ALU_SUB | c_A_LOAD | c_FLAGS_LOAD, 15'h0, 3'd4};
        tbl[5]  = '{4'h5, 1'b0, 1'b0, c_IR_OE | c_MAR_LOAD, c_A_OE | c_RAM_WE, 3'd5};
        tbl[6]  = '{4'h6, 1'b0, 1'b0, c_IR_OE | c_A_LOAD, 15'h0, 3'd4};
        tbl[7]  = '{4'h7, 1'b0, 1'b0, c_IR_OE | c_PC_LOAD, 15'h0, 3'd4};
        tbl[8]  = '{4'h8, 1'b1, 1'b0, c_IR_OE | c_PC_LOAD, 15'h0, 3'd4};
        tbl[9]  = '{4'h8, 1'b0, 1'b1, 15'h0, 15'h0, 3'd4};
        tbl[10] = '{4'h9, 1'b0, 1'b1, c_IR_OE | c_PC_LOAD, 15'h0, 3'd4};
        tbl[11] = '{4'h9, 1'b1, 1'b0, 15'h0, 15'h0, 3'd4};
        tbl[12] = '{4'hA, 1'b1, 1'b1, 15'h0, 15'h0, 3'd3};
        tbl[13] = '{4'hB, 1'b0, 1'b0, 15'h0, 15'h0, 3'd3};
        tbl[14] = '{4'hC, 1'b1, 1'b0, 15'h0, 15'h0, 3'd3};
        tbl[15] = '{4'hD, 1'b0, 1'b1, 15'h0, 15'h0, 3'd3};
        tbl[16] = '{4'hE, 1'b0, 1'b0, c_A_OE | c_O_LOAD, 15'h0, 3'd4};
        tbl[17] = '{4'h3, 1'b1, 1'b1, c_ALU_OE | c_A_LOAD | c_FLAGS_LOAD, 15'h0, 3'd4};
        for (int e = 0; e < 18; e++) begin
            op_tb = tbl[e].op;
            fc_tb = tbl[e].c;
            fz_tb = tbl[e].z;
            #1;
            for (int s = 0; s <= int'(tbl[e].len); s++) begin
                exp_st = S_FETCH_PC;
                exp_cw = c_FETCH_PC;
                case (s)
                    1: begin exp_st = S_FETCH_RAM; exp_cw = c_FETCH_RAM; end
                    2: begin exp_st = S_DECODE;    exp_cw = 15'h0;       end
                    3: if (tbl[e].len != 3'd3) begin exp_st = S_EX0; exp_cw = tbl[e].ex0; end
                    4: if (tbl[e].len != 3'd4) begin exp_st = S_EX1; exp_cw = tbl[e].ex1; end
                    default: ;
                endcase
                n_checks++;
                if (st !== exp_st || cw_bits !== exp_cw)
                    $display("FAIL decode op=%h c=%b z=%b step=%0d state=%0d cw=%h want state=%0d cw=%h",
                             tbl[e].op, tbl[e].c, tbl[e].z, s, st, cw_bits, exp_st, exp_cw);
                else n_pass++;
                if (s < int'(tbl[e].len)) tick();
            end
        end
    endtask

    task automatic test_system_program();
        int cyc;
        use_sys = 1'b1;
        reset   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        cyc   = 0;
        while (halt !== 1'b1 && cyc < 80) begin
            tick();
            cyc++;
        end
        n_checks++;
        if (halt !== 1'b1) $display("FAIL sys_halt_timeout halt=%b after %0d cycles want 1", halt, cyc);
        else n_pass++;
        n_checks++;
        if (m_b !== 8'h11) $display("FAIL sys_ldb B=%h want 11", m_b);
        else n_pass++;
        n_checks++;
        if (m_a !== 8'h16 || m_out !== 8'h16) $display("FAIL sys_add_out A=%h OUT=%h want 16/16", m_a, m_out);
        else n_pass++;
        use_sys = 1'b0;
    endtask

    task automatic test_halt();
        reset = 1'b1;
        op_tb = 4'hF;
        tick();
        reset = 1'b0;
        tick();
        tick();
        n_checks++;
        if (st !== S_DECODE || halt !== 1'b0) $display("FAIL halt_decode state=%0d halt=%b want 2/0", st, halt);
        else n_pass++;
        tick();
        n_checks++;
        if (st !== S_HALT || halt !== 1'b1 || cw_bits !== 15'h0)
            $display("FAIL halt_enter state=%0d halt=%b cw=%h want 5/1/0000", st, halt, cw_bits);
        else n_pass++;
        op_tb = 4'h1;
        repeat (20) tick();
        n_checks++;
        if (st !== S_HALT || halt !== 1'b1 || cw_bits !== 15'h0)
            $display("FAIL halt_sticky state=%0d halt=%b cw=%h want 5/1/0000", st, halt, cw_bits);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (halt !== 1'b0 || cw_bits !== 15'h0) $display("FAIL halt_reset_mask halt=%b cw=%h want 0/0000", halt, cw_bits);
        else n_pass++;
        tick();
        reset = 1'b0;
        #1;
        n_checks++;
        if (st !== S_FETCH_PC || halt !== 1'b0 || cw_bits !== c_FETCH_PC)
            $display("FAIL halt_exit state=%0d halt=%b cw=%h want 0/0/%h", st, halt, cw_bits, c_FETCH_PC);
        else n_pass++;
    endtask

    task automatic test_sta_reset_abort();
        op_tb = 4'h5;
        tick();
        tick();
        tick();
        n_checks++;
        if (st !== S_EX0 || cw_bits !== (c_IR_OE | c_MAR_LOAD))
            $display("FAIL sta_ex0 state=%0d cw=%h want 3/%h", st, cw_bits, c_IR_OE | c_MAR_LOAD);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++;
        if (cw_bits !== 15'h0) $display("FAIL sta_abort_word cw=%h want 0000", cw_bits);
        else n_pass++;
        tick();
        n_checks++;
        if (st !== S_FETCH_PC || cw.ram_we !== 1'b0)
            $display("FAIL sta_abort_state state=%0d ram_we=%b want 0/0", st, cw.ram_we);
        else n_pass++;
        reset = 1'b0;
        tick();
        n_checks++;
        if (st !== S_FETCH_RAM || cw.ram_we !== 1'b0)
            $display("FAIL sta_restart state=%0d ram_we=%b want 1/0", st, cw.ram_we);
        else n_pass++;
    endtask

    task automatic test_random_sweep();
        int drivers;
        for (int i = 0; i < 1000; i++) begin
            op_tb = 4'($urandom_range(15, 0));
            fc_tb = 1'($urandom_range(1, 0));
            fz_tb = 1'($urandom_range(1, 0));
            reset = (st == S_HALT);
            #1;
            drivers = $countones({cw.pc_oe, cw.ram_oe, cw.ir_oe, cw.a_oe, cw.alu_oe});
            n_checks++;
            if (drivers > 1 || (cw.ram_we & cw.ram_oe) !== 1'b0)
                $display("FAIL sweep_invariant cyc=%0d drivers=%0d we_oe=%b want <=1/0",
                         i, drivers, cw.ram_we & cw.ram_oe);
            else n_pass++;
            tick();
        end
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_decode_table();
        test_system_program();
        test_halt();
        test_sta_reset_abort();
        test_random_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
